// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: programmable HPM counters with multi-bit increments,
// per-privilege inhibits and sticky overflow flags behind a CSR read/write port.
module hpm_counter_bank #(
  parameter int NumCounters  = 8,
  parameter int CounterWidth = 64,
  parameter int NumEvents    = 32,
  parameter int IncWidth     = 2,
  parameter int XLEN         = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [1:0]                    priv_lvl_i,
  input  logic [11:0]                   csr_addr_i,
  input  logic                          csr_we_i,
  input  logic [XLEN-1:0]               csr_wdata_i,
  output logic [XLEN-1:0]               csr_rdata_o,
  output logic                          csr_err_o,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  input  logic [NumCounters-1:0]        mcountinhibit_i,
  output logic [NumCounters-1:0]        ovf_o,
  output logic                          ovf_irq_o
);
  localparam int SW = CounterWidth + IncWidth;
  logic [CounterWidth-1:0] cnt_q [NumCounters];
  logic [CounterWidth-1:0] cnt_d [NumCounters];
  logic [7:0] sel_q [NumCounters];
  logic [7:0] sel_d [NumCounters];
  logic [3:0] fl_q [NumCounters];
  logic [3:0] fl_d [NumCounters];
  logic [6:0] grp;
  logic [4:0] k_a;
  logic slot, is_cnt, is_cnth, is_ev, is_evh, is_ro, is_roh, is_c, is_e, is_h, wr_ok;
  logic [63:0] w64, rd64;
  assign grp = csr_addr_i[11:5];
  assign slot = csr_addr_i[4:0] >= 5'd3;
  assign k_a = csr_addr_i[4:0] - 5'd3;
  assign is_cnt = slot && grp == 7'h58;
  assign is_cnth = slot && grp == 7'h5C;
  assign is_ev = slot && grp == 7'h19;
  assign is_evh = slot && grp == 7'h39;
  assign is_ro = slot && grp == 7'h60;
  assign is_roh = slot && grp == 7'h64;
  assign is_c = is_cnt | is_cnth | is_ro | is_roh;
  assign is_e = is_ev | is_evh;
  assign is_h = is_cnth | is_evh | is_roh;
  assign csr_err_o = (is_h && XLEN == 64) || (csr_we_i && (is_ro || is_roh));
  assign wr_ok = csr_we_i && !csr_err_o;
  assign w64 = 64'(csr_wdata_i);
  assign csr_rdata_o = csr_err_o ? '0 : XLEN'(is_h ? rd64 >> 32 : rd64);
  assign ovf_irq_o = |ovf_o;
  // flag nibble layout: [3] OF, [2] MINH, [1] SINH, [0] UINH
  always_comb begin
    logic [63:0] c64, nw;
    logic [SW-1:0] sum;
    logic [IncWidth-1:0] inc;
    logic inh, en, hit, of, ev_wr;
    c64 = '0;
    nw = '0;
    sum = '0;
    inc = '0;
    inh = 1'b0;
    en = 1'b0;
    hit = 1'b0;
    of = 1'b0;
    ev_wr = 1'b0;
    rd64 = '0;
    ovf_o = '0;
    for (int i = 0; i < NumCounters; i++) begin
      inh = priv_lvl_i == 2'b00 ? fl_q[i][0] : priv_lvl_i == 2'b01 ? fl_q[i][1] : fl_q[i][2];
      en = !debug_mode_i && !mcountinhibit_i[i] && !inh && sel_q[i] != '0;
      inc = '0;
      for (int e = 0; e < NumEvents; e++)
        if (sel_q[i] == 8'(e)) inc = event_inc_i[e*IncWidth +: IncWidth];
      sum = SW'(cnt_q[i]) + SW'(inc);
      c64 = 64'(cnt_q[i]);
      hit = k_a == 5'(i);
      if (hit) rd64 = is_c ? c64 : is_e ? {fl_q[i], 52'b0, sel_q[i]} : '0;
      nw = XLEN == 64 ? w64 : is_cnth ? {w64[31:0], c64[31:0]} : {c64[63:32], w64[31:0]};
      of = fl_q[i][3] | (en && sum[SW-1:CounterWidth] != '0);
      cnt_d[i] = wr_ok && hit && is_c ? CounterWidth'(nw) : en ? sum[CounterWidth-1:0] : cnt_q[i];
      ev_wr = wr_ok && hit && is_e;
      fl_d[i] = ev_wr && (XLEN == 64 || is_evh) ? w64[XLEN-1 -: 4]
              : {wr_ok && hit && is_c ? fl_q[i][3] : of, fl_q[i][2:0]};
      sel_d[i] = ev_wr && (XLEN == 64 || is_ev) ? w64[7:0] : sel_q[i];
      ovf_o[i] = fl_q[i][3];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '{default: '0};
      sel_q <= '{default: '0};
      fl_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      fl_q <= fl_d;
    end
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: scoreboard bench; instance a is 8-bit/XLEN64, instance b is 64-bit/XLEN32.
module tb_hpm_counter_bank;
  logic clk = 0, rst_n = 0, dbg = 0;
  logic [1:0] priv = 2'b11;
  logic [63:0] ev = '0;
  logic [3:0] minh = '0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic a_we = 0, b_we = 0;
  logic [63:0] a_wd = '0;
  logic [31:0] b_wd = '0;
  logic [63:0] a_rd;
  logic [31:0] b_rd;
  logic a_err, b_err, a_irq, b_irq;
  logic [3:0] a_ovf, b_ovf;
  int n_chk = 0, n_fail = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];
  always #5 clk = ~clk;
  hpm_counter_bank #(.NumCounters(4), .CounterWidth(8), .NumEvents(32), .IncWidth(2), .XLEN(64)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .priv_lvl_i(priv),
    .csr_addr_i(a_addr), .csr_we_i(a_we), .csr_wdata_i(a_wd), .csr_rdata_o(a_rd),
    .csr_err_o(a_err), .event_inc_i(ev), .mcountinhibit_i(minh), .ovf_o(a_ovf), .ovf_irq_o(a_irq));
  hpm_counter_bank #(.NumCounters(4), .CounterWidth(64), .NumEvents(32), .IncWidth(2), .XLEN(32)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .priv_lvl_i(priv),
    .csr_addr_i(b_addr), .csr_we_i(b_we), .csr_wdata_i(b_wd), .csr_rdata_o(b_rd),
    .csr_err_o(b_err), .event_inc_i(ev), .mcountinhibit_i(minh), .ovf_o(b_ovf), .ovf_irq_o(b_irq));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input bit b, input logic [11:0] adr, input logic [63:0] d);
    if (b) begin b_addr = adr; b_wd = d[31:0]; b_we = 1; end
    else begin a_addr = adr; a_wd = d; a_we = 1; end
    @(negedge clk);
    a_we = 0;
    b_we = 0;
  endtask
  task automatic rd(input bit b, input logic [11:0] adr, input logic [63:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (b) b_addr = adr; else a_addr = adr;
    #1;
    chk(tag_q.pop_front(), b ? 64'(b_rd) : a_rd, exp_q.pop_front());
  endtask
  task automatic inc(input int e, input logic [1:0] v);
    ev[e*2 +: 2] = v;
  endtask
  initial begin
    @(negedge clk);
    repeat (3) begin
      ev = {$urandom, $urandom};
      wr(0, 12'h323, 64'h5);
    end
    rd(0, 12'hB03, 0, "rst_cnt3");
    rd(0, 12'h323, 0, "rst_evt3");
    rd(1, 12'hB03, 0, "rst_b_cnt3");
    chk("rst_irq", 64'(a_irq), 0);
    rst_n = 1;
    ev = '0;
    cyc(1);
    rd(0, 12'h323, 0, "evt3_after_rst");
    wr(0, 12'h323, 64'h5);
    inc(5, 2);
    cyc(10);
    ev = '0;
    rd(0, 12'hB03, 20, "multi_inc");
    minh = 4'b0001;
    inc(5, 2);
    cyc(5);
    ev = '0;
    minh = '0;
    rd(0, 12'hB03, 20, "minhibit_hold");
    wr(0, 12'hB04, 64'hFE);
    wr(0, 12'h324, 64'h1);
    inc(1, 3);
    cyc(1);
    ev = '0;
    rd(0, 12'hB04, 64'h01, "ovf_wrap");
    chk("ovf_bit", 64'(a_ovf[1]), 1);
    chk("ovf_irq", 64'(a_irq), 1);
    rd(0, 12'h324, 64'h8000_0000_0000_0001, "evt4_of_view");
    wr(0, 12'h324, 64'h1);
    chk("ovf_clr_irq", 64'(a_irq), 0);
    chk("ovf_clr_bit", 64'(a_ovf), 0);
    wr(0, 12'h323, 64'h1000_0000_0000_0001);
    wr(0, 12'hB03, 64'h0);
    inc(1, 1);
    priv = 2'b00;
    cyc(4);
    priv = 2'b11;
    cyc(4);
    rd(0, 12'hB03, 4, "priv_uinh");
    rd(0, 12'hB04, 9, "priv_free");
    dbg = 1;
    cyc(3);
    rd(0, 12'hB03, 4, "debug_hold");
    dbg = 0;
    ev = '0;
    wr(1, 12'h323, 64'h1);
    wr(1, 12'h324, 64'h2);
    inc(1, 1);
    inc(2, 1);
    cyc(3);
    wr(1, 12'hB03, 64'h100);
    rd(1, 12'hB03, 64'h100, "coll_n1");
    cyc(1);
    rd(1, 12'hB03, 64'h101, "coll_n2");
    rd(1, 12'hB04, 5, "coll_other");
    ev = '0;
    wr(1, 12'hB83, 64'hDEAD_BEEF);
    wr(1, 12'hB03, 64'h1);
    rd(1, 12'hB83, 64'hDEAD_BEEF, "x32_hi");
    rd(1, 12'hB03, 64'h1, "x32_lo");
    rd(1, 12'hC83, 64'hDEAD_BEEF, "x32_ro_hi");
    b_addr = 12'hC03;
    b_wd = 32'h7;
    b_we = 1;
    #1;
    chk("ro_wr_err", 64'(b_err), 1);
    chk("ro_wr_rdata", 64'(b_rd), 0);
    @(negedge clk);
    b_we = 0;
    rd(1, 12'hB03, 64'h1, "ro_unchanged");
    a_addr = 12'hB83;
    #1;
    chk("h64_err", 64'(a_err), 1);
    rd(0, 12'hB83, 0, "h64_rdata");
    a_addr = 12'h300;
    #1;
    chk("unmapped_err", 64'(a_err), 0);
    rd(0, 12'h300, 0, "unmapped_rdata");
    wr(0, 12'hB08, 64'h55);
    rd(0, 12'hB08, 0, "unimpl_rdata");
    chk("unimpl_err", 64'(a_err), 0);
    wr(0, 12'h325, 64'h8000_0000_0000_0000);
    chk("of_load_irq", 64'(a_irq), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_irq", 64'(a_irq), 0);
    rd(0, 12'hB04, 0, "async_rst_cnt");
    rst_n = 1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised hardware performance-monitor counter bank: a generalised successor to the fixed-size perf counter block. It provides NumCounters programmable counters (mhpmcounter3.., mhpmevent3..) of configurable width. Each counter can add a multi-bit increment per cycle, so several commit ports can be counted in one cycle. It also adds per-privilege inhibit bits and Sscofpmf-style sticky overflow flags with an interrupt output. The block sits beside the CSR file, which forwards CSR reads and writes to it; event sources across the core drive increment vectors.

## Interface
- NumCounters, 8: implemented counters, mapped to index 3..3+NumCounters-1; range 1..29.
- CounterWidth, 64: counter width in bits; range 1..64.
- NumEvents, 32: event selector space; selector 0 is "no event"; range 2..256.
- IncWidth, 2: width of each per-event increment.
- XLEN, 64: CSR data width; 32 or 64.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- debug_mode_i  in  1  high: no counter increments.
- priv_lvl_i  in  2  current privilege: 00 U, 01 S, 11 M.
- csr_addr_i  in  12  CSR address.
- csr_we_i  in  1  write strobe for csr_addr_i.
- csr_wdata_i  in  XLEN  write data.
- csr_rdata_o  out  XLEN  combinational read data for csr_addr_i.
- csr_err_o  out  1  combinational illegal-access flag.
- event_inc_i  in  NumEvents*IncWidth  increment for event e, at bits [e*IncWidth +: IncWidth]; slice 0 ignored.
- mcountinhibit_i  in  NumCounters  bit k inhibits counter k (CSR index 3+k).
- ovf_o  out  NumCounters  sticky OF flag of each counter.
- ovf_irq_o  out  1  OR of all OF flags.

## Operation
- Per counter k, registered state:
  - cnt_q[k], CounterWidth bits.
  - sel_q[k], 8 bits.
  - of_q[k], minh_q[k], sinh_q[k], uinh_q[k].
- 64-bit mhpmevent view:
  - [7:0] sel.
  - [63] OF, [62] MINH, [61] SINH, [60] UINH.
  - All other bits read 0 and ignore writes.
- Selector handling: sel values ≥ NumEvents behave as event 0. The stored value reads back as written.
- Counter k is enabled when all of the following hold:
  - debug_mode_i is low.
  - mcountinhibit_i[k] is low.
  - The inhibit bit for the current privilege is clear: MINH for M, SINH for S, UINH for U. priv_lvl_i = 10 counts as M.
  - sel is not 0.
- Increment: inc = event_inc_i slice of sel, zero-extended. When enabled, cnt_d = (cnt_q + inc) mod 2^CounterWidth.
- Overflow: when enabled and cnt_q + inc ≥ 2^CounterWidth, of_d = 1. OF is sticky; only a CSR write clears it.
- CSR address map, for k = 0..28:
  - 0xB03+k: mhpmcounter.
  - 0xB83+k: mhpmcounterh.
  - 0x323+k: mhpmevent.
  - 0x723+k: mhpmeventh.
  - 0xC03+k: hpmcounter, read-only.
  - 0xC83+k: hpmcounterh, read-only.
- Unimplemented slots (k ≥ NumCounters): read 0 and ignore writes, with no error.
- Read data width:
  - XLEN=64: the low address returns all 64 bits; counters are zero-extended above CounterWidth.
  - XLEN=32: the low address returns bits [31:0] and the "h" address returns [63:32].
- csr_err_o = 1 in these cases:
  - Any "h" address while XLEN=64.
  - A write (csr_we_i) to 0xC03..0xC9F.
  - On error, writes are discarded and csr_rdata_o = 0.
- Addresses outside the map return 0 with csr_err_o = 0.
- CSR write to a counter:
  - Replaces the addressed half with csr_wdata_i, truncated to CounterWidth, and overrides that counter's increment and overflow detection that cycle.
  - Other counters keep counting; there is no global stall.
- CSR write to mhpmevent or mhpmeventh: loads sel, OF and the inhibit bits directly. This overrides any overflow set in the same cycle.

## Timing
- Reset: all cnt_q, sel_q, of_q and inhibit bits are 0, so ovf_o = 0 and ovf_irq_o = 0.
- csr_rdata_o and csr_err_o depend only on csr_addr_i, csr_we_i and the registered state. Therefore csr_rdata_o and csr_err_o are 0 whenever the address is unmapped.
- Reads return the pre-update value: a read in the same cycle as a write returns the old value.
- Latency from event to count: event_inc_i in cycle N is visible in cnt_q and reads in cycle N+1.
- Overflow latency: ovf_o and ovf_irq_o rise in cycle N+1 after the wrapping increment in cycle N. Both are driven straight from flops plus an OR.
- A write in cycle N takes effect in cycle N+1. Its truncated value is the full result, with no increment added.
- Assertion of rst_ni mid-operation clears all state immediately, asynchronously. Counting resumes on the first clock edge after release.

## Test plan
- Reset: hold rst_ni low with events toggling. Required: all reads are 0, ovf_irq_o = 0. After release, mhpmevent3 reads 0.
- Multi-increment:
  - Stimulus: NumCounters=4; mhpmevent3 sel=5; event 5 increment = 2 for 10 cycles.
  - Required: mhpmcounter3 = 20.
  - Stimulus: then set mcountinhibit_i[0] = 1 for 5 cycles.
  - Required: the count stays at 20.
- Overflow:
  - Stimulus: CounterWidth=8; write mhpmcounter4 = 0xFE; sel=1; increment 3 for one cycle.
  - Required: count = 0x01, ovf_o[1] = 1, ovf_irq_o = 1 the following cycle.
  - Stimulus: write mhpmevent4 with OF = 0.
  - Required: ovf_irq_o = 0 next cycle.
- Privilege filter:
  - Stimulus: mhpmevent3 with UINH=1 and sel=1, increment 1. Run 4 cycles at priv 00, then 4 cycles at priv 11.
  - Required: count = 4.
  - Stimulus: 3 cycles with debug_mode_i = 1.
  - Required: no change.
- Write collision:
  - Stimulus: counter 3 counting by 1; write 0x100 in cycle N; counter 4 also counting.
  - Required: counter 3 = 0x100 at N+1 and 0x101 at N+2. Counter 4 misses no increments.
- XLEN=32 and errors:
  - Stimulus: write 0xB83 = 0xDEAD_BEEF and 0xB03 = 0x1.
  - Required: reads return 0xDEAD_BEEF and 0x1. 0xC83 mirrors 0xB83.
  - Stimulus: write to 0xC03.
  - Required: csr_err_o = 1 and the value is unchanged.
  - Stimulus: under XLEN=64, read 0xB83.
  - Required: csr_err_o = 1.
